// File: rtl/par_bus_initiator.sv
// rtl/par_bus_initiator.sv - PAR bus initiator with command FIFO and read response port
//
// Purpose: accepts read/write commands from a local requester into a small FIFO and
// issues them one at a time as single PAR accesses. Read results (or a no-select error)
// come back on a valid/ready response port. reqRequest flags pending work for clock gating.
//
// Ports:
//   ck, arst                      clock, asynchronous active-high reset
//   cmdValid/cmdReady             command handshake (cmdReady = FIFO not full)
//   cmdWrite/cmdAddr/cmdData/cmdStrb  command payload
//   rspValid/rspReady             read response handshake
//   rspData/rspError              read data (0 on error), no-select error flag
//   parAddr/parDo/parRe/parWe     registered PAR access outputs
//   parDi/parDiSelect             PAR return data and select
//   busy                          FSM active or FIFO not empty
//   reqRequest                    busy | cmdValid
module par_bus_initiator #(
  parameter int PAR_AW       = 12,
  parameter int PAR_DW       = 32,
  parameter int PAR_WW       = PAR_DW / 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              ck,
  input  logic              arst,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdWrite,
  input  logic [PAR_AW-1:0] cmdAddr,
  input  logic [PAR_DW-1:0] cmdData,
  input  logic [PAR_WW-1:0] cmdStrb,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [PAR_DW-1:0] rspData,
  output logic              rspError,
  output logic [PAR_AW-1:0] parAddr,
  output logic [PAR_DW-1:0] parDo,
  output logic              parRe,
  output logic [PAR_WW-1:0] parWe,
  input  logic [PAR_DW-1:0] parDi,
  input  logic              parDiSelect,
  output logic              busy,
  output logic              reqRequest
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 1 + PAR_AW + PAR_DW + PAR_WW;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  state_t            state_q, state_d;
  logic              acc_write_q, acc_write_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [PAR_AW-1:0] par_addr_q, par_addr_d;
  logic [PAR_DW-1:0] par_do_q, par_do_d;
  logic              par_re_q, par_re_d;
  logic [PAR_WW-1:0] par_we_q, par_we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [PAR_DW-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;

  logic              push, pop, fifo_empty;
  logic              head_write;
  logic [PAR_AW-1:0] head_addr;
  logic [PAR_DW-1:0] head_data;
  logic [PAR_WW-1:0] head_strb;

  assign cmdReady   = (count_q != CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cmdValid & cmdReady;
  assign {head_write, head_addr, head_data, head_strb} = fifo_mem[rd_ptr_q];

  assign busy       = (state_q != IDLE) | !fifo_empty;
  assign reqRequest = busy | cmdValid;

  assign parAddr  = par_addr_q;
  assign parDo    = par_do_q;
  assign parRe    = par_re_q;
  assign parWe    = par_we_q;
  assign rspValid = rsp_valid_q;
  assign rspData  = rsp_data_q;
  assign rspError = rsp_error_q;

  // FIFO storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge ck) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmdWrite, cmdAddr, cmdData, cmdStrb};
    end
  end

  // PAR outputs are computed for the state being entered, so they are
  // registered and aligned with that state (ISSUE/WAIT_RD) on the bus.
  always_comb begin
    state_d     = state_q;
    acc_write_d = acc_write_q;
    lat_cnt_d   = lat_cnt_q;
    par_addr_d  = '0;
    par_do_d    = '0;
    par_re_d    = 1'b0;
    par_we_d    = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          acc_write_d = head_write;
          state_d     = ISSUE;
          if (!head_write) begin
            par_addr_d = head_addr;
            par_re_d   = 1'b1;
          end else if (head_strb != '0) begin
            par_addr_d = head_addr;
            par_do_d   = head_data;
            par_we_d   = head_strb;
          end
        end
      end
      ISSUE: begin
        if (acc_write_q) begin
          state_d = IDLE;
        end else begin
          state_d    = WAIT_RD;
          lat_cnt_d  = '0;
          par_addr_d = par_addr_q;
        end
      end
      WAIT_RD: begin
        if (lat_cnt_q == 3'(READ_LATENCY - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = parDiSelect ? parDi : '0;
          rsp_error_d = !parDiSelect;
          state_d     = RESP;
        end else begin
          lat_cnt_d  = lat_cnt_q + 3'd1;
          par_addr_d = par_addr_q;
        end
      end
      RESP: begin
        if (rspReady) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_error_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_write_q <= 1'b0;
      lat_cnt_q   <= '0;
      par_addr_q  <= '0;
      par_do_q    <= '0;
      par_re_q    <= 1'b0;
      par_we_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_write_q <= acc_write_d;
      lat_cnt_q   <= lat_cnt_d;
      par_addr_q  <= par_addr_d;
      par_do_q    <= par_do_d;
      par_re_q    <= par_re_d;
      par_we_q    <= par_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
